// File: rtl/sfq_and_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sfq_and_monitor
// Brief    : Reference-model checker for a clocked SFQ AND cell. Decodes
//            toggle-encoded pulses, tracks the cell's stored-input state,
//            checks the output pulse window and keeps saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module sfq_and_monitor #(
  parameter int OUT_WINDOW = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             sfq_clk_i,
  input  logic             out_i,
  output logic [1:0]       state_o,
  output logic             busy_o,
  output logic             pass_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [CNT_W-1:0] pulse_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  // Bit 0 = A stored, bit 1 = B stored.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_A     = 2'd1,
    S_B     = 2'd2,
    S_AB    = 2'd3
  } state_e;

  localparam logic [1:0]       c_err_none  = 2'd0;
  localparam logic [1:0]       c_err_dup   = 2'd1;
  localparam logic [1:0]       c_err_miss  = 2'd2;
  localparam logic [1:0]       c_err_spur  = 2'd3;
  localparam logic [3:0]       c_window    = 4'(OUT_WINDOW);
  localparam logic [CNT_W-1:0] c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

  // Previous input levels for pulse (level-change) detection.
  logic a_prev_q, b_prev_q, clk_prev_q, out_prev_q;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic [3:0]         timer_q, timer_d;
  logic               pass_q, pass_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [CNT_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic w_a_pulse, w_b_pulse, w_clk_pulse, w_out_pulse;
  logic [1:0] w_post_clk;
  logic w_expected, w_dup, w_missing, w_spurious;

  assign w_a_pulse   = a_i ^ a_prev_q;
  assign w_b_pulse   = b_i ^ b_prev_q;
  assign w_clk_pulse = sfq_clk_i ^ clk_prev_q;
  assign w_out_pulse = out_i ^ out_prev_q;

  // Cell model, window checker, error priority and counter next-state.
  always_comb begin
    w_post_clk  = state_q;
    w_expected  = 1'b0;
    w_missing   = 1'b0;
    w_spurious  = 1'b0;
    pass_d      = 1'b0;
    busy_d      = busy_q;
    timer_d     = timer_q;
    err_code_d  = c_err_none;
    pulse_cnt_d = pulse_cnt_q;
    err_cnt_d   = err_cnt_q;

    // Gate clock is applied first; data pulses then land on the cleared state.
    if (w_clk_pulse) begin
      w_expected = (state_q == S_AB);
      w_post_clk = S_EMPTY;
    end
    w_dup   = (w_a_pulse & w_post_clk[0]) | (w_b_pulse & w_post_clk[1]);
    state_d = state_e'(w_post_clk | {w_b_pulse, w_a_pulse});

    // An out pulse is judged against the window pending before this edge.
    if (w_out_pulse) begin
      if (busy_q) begin
        pass_d  = 1'b1;
        busy_d  = 1'b0;
        timer_d = 4'd0;
      end else begin
        w_spurious = 1'b1;
      end
    end else if (busy_q) begin
      // Timer expiry or re-arming both close the old window as missing.
      if (w_expected || (timer_q == 4'd1)) begin
        w_missing = 1'b1;
        busy_d    = 1'b0;
        timer_d   = 4'd0;
      end else begin
        timer_d = timer_q - 4'd1;
      end
    end

    if (w_expected) begin
      busy_d  = 1'b1;
      timer_d = c_window;
    end

    err_d = w_missing | w_spurious | w_dup;
    if (w_missing) begin
      err_code_d = c_err_miss;
    end else if (w_spurious) begin
      err_code_d = c_err_spur;
    end else if (w_dup) begin
      err_code_d = c_err_dup;
    end

    if (w_out_pulse && (pulse_cnt_q != c_cnt_max)) begin
      pulse_cnt_d = pulse_cnt_q + c_cnt_one;
    end
    if (err_d && (err_cnt_q != c_cnt_max)) begin
      err_cnt_d = err_cnt_q + c_cnt_one;
    end
  end

  // State register; reset captures live input levels so no false pulse follows.
  always_ff @(posedge clk) begin
    a_prev_q   <= a_i;
    b_prev_q   <= b_i;
    clk_prev_q <= sfq_clk_i;
    out_prev_q <= out_i;
    if (rst) begin
      state_q     <= S_EMPTY;
      busy_q      <= 1'b0;
      timer_q     <= 4'd0;
      pass_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= c_err_none;
      pulse_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      timer_q     <= timer_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      pulse_cnt_q <= pulse_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign state_o     = state_q;
  assign busy_o      = busy_q;
  assign pass_o      = pass_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign pulse_cnt_o = pulse_cnt_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
`default_nettype wire

// File: doc/sfq_and_monitor.md
# sfq_and_monitor

Synchronous checker that sits directly downstream of the clocked SFQ AND cell in simulation benches. It watches the cell's toggle-encoded inputs (a, b, gate clock) and its output, runs a reference model of the AND cell's state machine, and checks that every predicted output pulse arrives within a bounded window. It reports pass/fail pulses, error codes and saturating counters. This gives regression benches a self-checking result instead of a $monitor trace.

## Interface
- OUT_WINDOW, 4: number of clk cycles after a gate-clock pulse in which the output pulse must arrive (1..15)
- CNT_W, 16: width of the pulse and error counters
- clk  in  1  system sampling clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- a  in  1  toggle-encoded SFQ data input A of the monitored cell
- b  in  1  toggle-encoded SFQ data input B
- sfq_clk  in  1  toggle-encoded gate clock of the monitored cell
- out  in  1  toggle-encoded output of the monitored cell
- state  out  2  model state: 0 empty, 1 A stored, 2 B stored, 3 both stored
- busy  out  1  output window pending
- pass  out  1  one-cycle strobe: expected output pulse arrived in window
- err  out  1  one-cycle strobe: any error this cycle
- err_code  out  2  code of the highest-priority error this cycle: 1 DUP, 2 MISSING, 3 SPURIOUS; 0 when err=0
- pulse_cnt  out  CNT_W  total output pulses observed, saturating
- err_cnt  out  CNT_W  cycles with err=1, saturating

## Operation
- Pulse encoding: every level change on a, b, sfq_clk or out is one SFQ pulse.
- Inputs must hold each level for at least 1 clk cycle.
- Detection: one prev register per input; pulse = input XOR prev; prev updated every edge.
- Model FSM, gate clock first, then data:
  - sfq_clk pulse: expected = (state==3); state -> 0; if expected, arm window (busy=1, timer=OUT_WINDOW).
  - a pulse: 0->1, 2->3. In 1 or 3, state is unchanged and a DUP error is raised.
  - b pulse: 0->2, 1->3. In 2 or 3, state is unchanged and a DUP error is raised.
  - a and b in the same cycle from state 0: -> 3.
  - Data pulse in the same cycle as sfq_clk: applied to the post-clock state 0. Example: state 3 + sfq_clk + a gives expected=1 and final state 1.
- Window checker:
  - out pulse while busy: pass=1, busy cleared.
  - out pulse while not busy: SPURIOUS error.
  - Timer decrements each cycle while busy. If it reaches 0 with no out pulse: MISSING error, busy cleared.
  - New arming sfq_clk pulse while busy:
    - If out arrives the same cycle, the old window passes.
    - Otherwise the old window reports MISSING.
    - In both cases the new window arms.
- pulse_cnt increments on every detected out pulse, pass or spurious.
- err_cnt increments by 1 per cycle with err=1.
- Both counters stick at all-ones.
- err_code priority when several errors coincide: MISSING > SPURIOUS > DUP.
- Reset:
  - state=0, busy=0, pass=0, err=0, err_code=0, counters=0, timer=0.
  - prev registers load current input levels, so no pulse is detected on the first cycle after reset.
- Reset mid-operation aborts any pending window silently (no MISSING reported).

## Timing
- A pulse whose level change precedes edge k is detected at edge k. state, busy, pass, err, err_code and counters reflect it immediately after edge k.
- No combinational paths from inputs to outputs.
- Window armed at edge k:
  - An out pulse detected at edges k+1..k+OUT_WINDOW passes.
  - An out pulse at edge k is evaluated against the window pending before edge k; if none, it is SPURIOUS.
  - With no out pulse, MISSING is strobed at edge k+OUT_WINDOW.
- pass and err are single-cycle strobes. Both may be 1 in the same cycle (e.g. pass plus DUP).
- Throughput: one event of each kind per cycle.

## Test plan
- Reset, then toggle a at t=2, a at t=4, b at t=6, sfq_clk at t=8, out at t=10 (OUT_WINDOW=4) -> state 1, 1 with err_code=1, 3, then 0; pass at t=10; pulse_cnt=1, err_cnt=1.
- State 2, sfq_clk -> no window armed. out toggled 2 cycles later -> err_code=3, pulse_cnt=1.
- State 3, sfq_clk, no out -> err_code=2 exactly OUT_WINDOW cycles later; busy falls the same cycle.
- State 3, sfq_clk and a in the same cycle -> busy=1, state=1. out on the next cycle -> pass=1.
- Window pending, rst asserted for 1 cycle with inputs at level 1 -> all outputs 0, no pulses detected after release, no MISSING reported.
- CNT_W=2, 5 spurious out pulses -> pulse_cnt and err_cnt hold at 3.
